apb_spi_periph: RTL

APB responder peripheral that adds an SPI master port (mode 0, 8-bit, MSB first) to the MCU peripheral set. It sits on one PSEL slot of the APB bus, alongside the UART, timer and GPIO peripherals. Software writes a byte to start a transfer, polls a status register, and reads back the received byte. It contains an APB slave register file and a clock-divided SPI shift engine.

---
 rtl/apb_spi_periph.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/apb_spi_periph.sv
// apb_spi_periph
// APB responder with an SPI master port (mode 0, 8-bit, MSB first).
// Software writes TXDR to start a transfer, polls SR, then reads RXDR.
//
// Ports
//   PCLK     in   system clock (only clock)
//   PRESET   in   synchronous active-high reset
//   PADDR    in   byte address, only [3:2] decoded
//   PWDATA   in   write data
//   PWRITE   in   1 = write, 0 = read
//   PENABLE  in   APB access phase
//   PSEL     in   slot select
//   PRDATA   out  read data, valid while PREADY=1, else 0
//   PREADY   out  registered transfer complete (one wait state)
//   sclk     out  SPI clock, idle low
//   mosi     out  SPI data out
//   miso     in   SPI data in
//   cs_n     out  chip select, active low
//
// Register map (PADDR[3:2])
//   0 CR    [0] EN, [15:8] CLKDIV
//   1 SR    [0] BUSY, [1] DONE (sticky), [2] WCOL (sticky, write 1 to clear)
//   2 TXDR  [7:0]
//   3 RXDR  [7:0], read-only
//
// SPI engine states
//   state  | meaning
//   S_IDLE | no transfer, cs_n high, sclk low
//   S_LOW  | sclk low half-period, mosi holds current bit
//   S_HIGH | sclk high half-period, miso sample held in rx_bit
module apb_spi_periph (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

  localparam logic [1:0] A_CR   = 2'd0;
  localparam logic [1:0] A_SR   = 2'd1;
  localparam logic [1:0] A_TXDR = 2'd2;
  localparam logic [1:0] A_RXDR = 2'd3;

  state_t      state, state_nxt;
  logic [7:0]  hcnt;
  logic [2:0]  bitcnt;
  logic [7:0]  shreg;
  logic        rx_bit;

  logic        en;
  logic [7:0]  clkdiv;
  logic [7:0]  txdr;
  logic [7:0]  rxdr;
  logic        done;
  logic        wcol;
  logic        busy;

  logic [1:0]  addr;
  logic        access;
  logic        wr_commit;
  logic        rd_commit;
  logic [31:0] rd_mux;

  logic        start;
  logic        rise;
  logic        fall;
  logic        last;

  logic        unused_bits;
  assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

  assign addr      = PADDR[3:2];
  // access is the first PENABLE cycle; commit is the cycle PREADY is high
  assign access    = PSEL & PENABLE & ~PREADY;
  assign wr_commit = PSEL & PENABLE & PREADY & PWRITE;
  assign rd_commit = PSEL & PENABLE & PREADY & ~PWRITE;
  assign busy      = (state != S_IDLE);

  always_comb begin
    rd_mux = 32'd0;
    case (addr)
      A_CR:    rd_mux = {16'd0, clkdiv, 7'd0, en};
      A_SR:    rd_mux = {29'd0, wcol, done, busy};
      A_TXDR:  rd_mux = {24'd0, txdr};
      A_RXDR:  rd_mux = {24'd0, rxdr};
      default: rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    rise      = 1'b0;
    fall      = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_commit && addr == A_TXDR && en) begin
          start     = 1'b1;
          state_nxt = S_LOW;
        end
      end
      S_LOW: begin
        if (hcnt == 8'd0) begin
          rise      = 1'b1;
          state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        if (hcnt == 8'd0) begin
          fall = 1'b1;
          if (bitcnt == 3'd7) begin
            last      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_LOW;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PREADY <= 1'b0;
      PRDATA <= 32'd0;
      sclk   <= 1'b0;
      mosi   <= 1'b0;
      cs_n   <= 1'b1;
      hcnt   <= 8'd0;
      bitcnt <= 3'd0;
      shreg  <= 8'd0;
      rx_bit <= 1'b0;
      en     <= 1'b0;
      clkdiv <= 8'd0;
      txdr   <= 8'd0;
      rxdr   <= 8'd0;
      done   <= 1'b0;
      wcol   <= 1'b0;
    end else begin
      PREADY <= access;
      PRDATA <= access ? rd_mux : 32'd0;

      // half-period down-counter; reload picks up the current CLKDIV
      if (start || rise || (fall && !last)) hcnt <= clkdiv;
      else if (busy)                        hcnt <= hcnt - 8'd1;

      if (start) begin
        shreg  <= PWDATA[7:0];
        mosi   <= PWDATA[7];
        cs_n   <= 1'b0;
        bitcnt <= 3'd0;
      end

      if (rise) begin
        sclk   <= 1'b1;
        rx_bit <= miso;
      end

      if (fall) begin
        sclk   <= 1'b0;
        shreg  <= {shreg[6:0], rx_bit};
        mosi   <= shreg[6];
        bitcnt <= bitcnt + 3'd1;
        if (last) begin
          rxdr <= {shreg[6:0], rx_bit};
          cs_n <= 1'b1;
        end
      end

      if (wr_commit) begin
        case (addr)
          A_CR: begin
            en     <= PWDATA[0];
            clkdiv <= PWDATA[15:8];
          end
          A_SR: begin
            if (PWDATA[2]) wcol <= 1'b0;
          end
          A_TXDR: begin
            // busy is still high on the completion edge, so that write collides too
            if (busy) wcol <= 1'b1;
            else      txdr <= PWDATA[7:0];
          end
          default: ;
        endcase
      end

      // completion set wins over a same-edge clear
      if (last)
        done <= 1'b1;
      else if ((wr_commit && addr == A_TXDR) || (rd_commit && addr == A_RXDR))
        done <= 1'b0;
    end
  end

endmodule
